// File: rtl/mux_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Purpose  : N-channel, WIDTH-bit registered multiplexer with two modes.
//            In manual mode the channel is picked by sel. In scan mode an
//            internal dwell counter steps through every channel in turn.
//            The block reports which channel is currently driven out.
// Ports    : clk      - rising-edge clock
//            rst_n    - asynchronous active-low reset
//            din      - packed channels, channel k at din[k*WIDTH +: WIDTH]
//            sel      - channel index used in manual mode
//            mode     - 0 = manual, 1 = scan
//            en       - 1 = run, 0 = freeze (IDLE)
//            out      - registered data of the selected channel
//            ch       - index of the channel currently shown on out
//            valid    - out/ch carry legal channel data this cycle
//            ch_wrap  - one-cycle pulse when scan wraps from last channel to 0
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 4,
    parameter  int DWELL    = 20,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           ch,
    output logic                      valid,
    output logic                      ch_wrap
);

    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [SELW-1:0] c_CH_LAST    = SELW'(CHANNELS - 1);
    localparam logic [SELW:0]   c_CH_COUNT   = (SELW + 1)'(CHANNELS);
    localparam logic [CNTW-1:0] c_DWELL_LAST = CNTW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t          r_state;
    logic [SELW-1:0] r_ptr;
    logic [CNTW-1:0] r_cnt;
    // Set when the pointer has just wrapped to 0; the pulse itself is emitted
    // on the edge that first shows channel 0, which may be after a freeze.
    logic            r_wrap_pend;

    logic            w_scan_restart;
    logic [SELW-1:0] w_ptr;
    logic [CNTW-1:0] w_cnt;
    logic            w_sel_ok;
    logic            w_dwell_done;
    logic            w_ptr_last;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_scan_data;

    always_comb begin
        // Coming straight from MANUAL restarts the scan at channel 0, dwell 0.
        // Coming from IDLE keeps the frozen pointer and counter.
        w_scan_restart = (r_state == S_MANUAL);
        w_ptr          = w_scan_restart ? '0 : r_ptr;
        w_cnt          = w_scan_restart ? '0 : r_cnt;
        // sel can exceed the channel count only when CHANNELS is not a power of two
        w_sel_ok       = ({1'b0, sel} < c_CH_COUNT);
        w_dwell_done   = (w_cnt == c_DWELL_LAST);
        w_ptr_last     = (w_ptr == c_CH_LAST);
        w_sel_data     = '0;
        w_scan_data    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) begin
                w_sel_data = din[k*WIDTH +: WIDTH];
            end
            if (w_ptr == SELW'(k)) begin
                w_scan_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_wrap_pend <= 1'b0;
            out         <= '0;
            ch          <= '0;
            valid       <= 1'b0;
            ch_wrap     <= 1'b0;
        end else if (!en) begin
            // Freeze: out/ch and the scan position hold, only the flags drop.
            r_state <= S_IDLE;
            valid   <= 1'b0;
            ch_wrap <= 1'b0;
        end else if (!mode) begin
            r_state <= S_MANUAL;
            ch      <= sel;
            valid   <= w_sel_ok;
            out     <= w_sel_ok ? w_sel_data : '0;
            ch_wrap <= 1'b0;
        end else begin
            r_state <= S_SCAN;
            out     <= w_scan_data;
            ch      <= w_ptr;
            valid   <= 1'b1;
            ch_wrap <= r_wrap_pend & ~w_scan_restart;
            if (w_dwell_done) begin
                r_cnt       <= '0;
                r_ptr       <= w_ptr_last ? '0 : w_ptr + 1'b1;
                r_wrap_pend <= w_ptr_last;
            end else begin
                r_cnt       <= w_cnt + 1'b1;
                r_ptr       <= w_ptr;
                r_wrap_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, WIDTH-bit registered multiplexer with two modes: manual select and auto-scan. In auto-scan mode an internal dwell counter steps through the channels in turn. The block is the clocked successor of the team's combinational 4:1 mux. It sits between parallel sensor or data lanes and a single serial consumer, and reports which channel is currently being driven out.

## Interface
- `WIDTH`, default 1: bits per channel.
- `CHANNELS`, default 4: number of input channels, ≥2, need not be a power of two.
- `DWELL`, default 20: cycles spent on each channel in scan mode, ≥1.
- `SELW`: localparam, `$clog2(CHANNELS)`.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `din`, input, CHANNELS*WIDTH: channel k occupies `din[k*WIDTH +: WIDTH]`.
- `sel`, input, SELW: channel index in manual mode.
- `mode`, input, 1: 0 = manual, 1 = scan.
- `en`, input, 1: 1 = run, 0 = freeze.
- `out`, output, WIDTH: registered selected channel data.
- `ch`, output, SELW: index of the channel currently in `out`.
- `valid`, output, 1: `out`/`ch` hold legal channel data this cycle.
- `ch_wrap`, output, 1: one-cycle pulse when scan steps from channel CHANNELS-1 to 0.

## Operation
- **Reset values** (rst_n low, applied immediately): `out`=0, `ch`=0, `valid`=0, `ch_wrap`=0. The dwell counter is 0, the scan pointer is 0 and the state is IDLE.
- **States**: IDLE, MANUAL, SCAN. Transitions are evaluated each rising edge:
  - `en`=0 → IDLE from any state.
  - `en`=1 and `mode`=0 → MANUAL.
  - `en`=1 and `mode`=1 → SCAN.
- **IDLE**:
  - `out` and `ch` hold their last values.
  - `valid`=0 and `ch_wrap`=0.
  - The dwell counter and scan pointer freeze; they are not cleared.
- **MANUAL**:
  - Every cycle, `out` ← channel `sel` and `ch` ← `sel`.
  - If `sel` ≥ CHANNELS (possible only for non-power-of-two counts), `out` ← 0, `ch` ← `sel`, `valid` ← 0. Otherwise `valid` ← 1.
  - The scan pointer and dwell counter are not touched.
- **SCAN**:
  - Every cycle, `out` ← channel at the scan pointer, `ch` ← scan pointer, `valid` ← 1.
  - The dwell counter runs 0..DWELL-1. When it reaches DWELL-1 it returns to 0 and the scan pointer advances by 1.
  - When the pointer advances from CHANNELS-1 it wraps to 0, and `ch_wrap` pulses high for exactly one cycle.
  - With DWELL=1 the pointer advances every cycle.
- **Entry to SCAN from MANUAL** (mode 0→1 with `en`=1): the scan pointer and dwell counter are cleared to 0, so scanning always restarts at channel 0.
- **Resume from IDLE into SCAN** with `mode` unchanged: scanning continues from the frozen pointer and counter.
- **Changes on `din`**: `din` is sampled every active cycle. A change on the selected channel appears on `out` one cycle later, even mid-dwell.

## Timing
- **Latency**: input to `out` is 1 cycle in both modes. `out`, `ch`, `valid` and `ch_wrap` all change on the same edge.
- **First cycle after `en` rises**: the edge that samples `en`=1 loads `out` and sets `valid`=1.
- **`en` falling**: the first edge that samples `en`=0 drops `valid` and freezes the state.
- **Scan dwell**: each channel appears on `out` for exactly DWELL consecutive active cycles. A full rotation is CHANNELS*DWELL active cycles.
- **`ch_wrap` alignment**: it asserts in the same cycle that `ch` first shows 0 after CHANNELS-1.
- **Simultaneous events**:
  - `en` falling on the dwell-terminal cycle: `en` wins. No advance and no `ch_wrap`.
  - mode 0→1 together with `en` 0→1: treated as SCAN entry from IDLE, so the counter is not cleared.
- **Reset mid-scan**: outputs clear asynchronously. After release, the first active edge starts from channel 0, dwell 0.

## Test plan
- **Manual select**: CHANNELS=4, WIDTH=1, `din`=4'b0101, `mode`=0, `en`=1; `sel` steps 0,1,2,3 every 20 cycles. Required: `out` = 1, 0, 1, 0 each one cycle after the `sel` change; `ch` tracks `sel`; `valid`=1 throughout.
- **Scan rotation**: DWELL=20, `din`=4'b0101, `mode`=1.
  - `ch` holds 0,1,2,3 for 20 cycles each, with `out` = 1, 0, 1, 0.
  - `ch_wrap` is high for exactly one cycle at active cycle 80, with `ch`=0.
- **Freeze/resume**: in scan, drop `en` on the 7th cycle of channel 2 for 10 cycles.
  - During the freeze: `valid`=0 and `out`/`ch` hold.
  - After resume: channel 2 persists for the remaining 13 cycles.
- **Mode switch**: scanning at `ch`=3, switch `mode` to 0 with `sel`=1, then back to 1. Required: `ch`=1 one cycle after the first switch, and `ch`=0 with a fresh dwell of 20 after returning to scan.
- **Non-power-of-two**: CHANNELS=3, `sel`=3 in manual mode. Required: `out`=0 and `valid`=0. In scan mode the wrap goes 2→0 and index 3 never appears.
- **Async reset**: assert `rst_n` low mid-dwell between clock edges. Required: all outputs are 0 before the next edge; after release, scanning restarts at `ch`=0.
